// File: rtl/interrupt_controller_pkg.sv
// Shared types and constants for the interrupt controller.
package interrupt_controller_pkg;

  localparam int INTC_IRQ_ID_WIDTH = 3;

  typedef enum logic [1:0] {
    INTC_STATE_IDLE       = 2'd0,
    INTC_STATE_REQUEST    = 2'd1,
    INTC_STATE_IN_SERVICE = 2'd2
  } intc_state_e;

endpackage

// File: rtl/interrupt_controller_prio_enc.sv
// Fixed-priority encoder: the lowest set index wins.
module intc_priority_encoder
  import interrupt_controller_pkg::*;
#(
  parameter int IRQ_COUNT = 4
) (
  input  logic [IRQ_COUNT-1:0]         req_i,
  output logic                         valid_o,
  output logic [INTC_IRQ_ID_WIDTH-1:0] index_o
);

  // Scan from the top down so the lowest set bit is the last assignment.
  always_comb begin
    valid_o = 1'b0;
    index_o = '0;
    for (int i = IRQ_COUNT - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        index_o = INTC_IRQ_ID_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: edge-latches peripheral requests, arbitrates by
// fixed priority and hands one interrupt at a time to the decode stage.
// Optional macro INTC_MASK_EN adds a writable per-line enable register.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int IRQ_COUNT     = 4,
  parameter int PC_WIDTH      = 10,
  parameter int VECTOR_BASE   = 1,
  parameter int VECTOR_STRIDE = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [IRQ_COUNT-1:0]         irq_lines,
  input  logic                         sreg_i,
  input  logic                         pipeline_ready,
  input  logic                         irq_ack,
  input  logic                         reti_done,
`ifdef INTC_MASK_EN
  input  logic                         mask_we,
  input  logic [IRQ_COUNT-1:0]         mask_wdata,
`endif
  output logic                         irq,
  output logic [PC_WIDTH-1:0]          isr_vector,
  output logic [INTC_IRQ_ID_WIDTH-1:0] irq_id,
  output logic [IRQ_COUNT-1:0]         pending,
  output logic                         in_service
);

  intc_state_e                  state_q;
  logic                         irq_q, in_service_q;
  logic [INTC_IRQ_ID_WIDTH-1:0] irq_id_q;
  logic [PC_WIDTH-1:0]          vec_q, vec_sel;
  logic [IRQ_COUNT-1:0]         hist_q, pending_q, pending_d;
  logic [IRQ_COUNT-1:0]         rise, clr, enable;
  logic                         ack_hit, sel_valid;
  logic [INTC_IRQ_ID_WIDTH-1:0] sel_idx;

`ifdef INTC_MASK_EN
  logic [IRQ_COUNT-1:0] enable_q;

  // Per-line enable register; masked lines still latch but do not arbitrate.
  always_ff @(posedge clk) begin
    if (reset)        enable_q <= '1;
    else if (mask_we) enable_q <= mask_wdata;
  end
  assign enable = enable_q;
`else
  assign enable = '1;
`endif

  assign rise    = irq_lines & ~hist_q;
  assign ack_hit = (state_q == INTC_STATE_REQUEST) && irq_ack;

  // Next pending: clear the acknowledged line, but a same-cycle edge re-sets it.
  always_comb begin
    clr = '0;
    for (int k = 0; k < IRQ_COUNT; k++) begin
      if (k == int'(irq_id_q)) clr[k] = ack_hit;
    end
    pending_d = (pending_q & ~clr) | rise;
  end

  // Edge-detect history and pending latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q    <= '0;
      pending_q <= '0;
    end else begin
      hist_q    <= irq_lines;
      pending_q <= pending_d;
    end
  end

  intc_priority_encoder #(.IRQ_COUNT(IRQ_COUNT)) u_prio (
    .req_i   (pending_q & enable),
    .valid_o (sel_valid),
    .index_o (sel_idx)
  );

  // Vector wraps modulo 2^PC_WIDTH by construction of the operand widths.
  assign vec_sel = PC_WIDTH'(VECTOR_BASE)
                 + PC_WIDTH'(sel_idx) * PC_WIDTH'(VECTOR_STRIDE);

  // Request/service FSM with registered outputs; id and vector freeze in REQUEST.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= INTC_STATE_IDLE;
      irq_q        <= 1'b0;
      in_service_q <= 1'b0;
      irq_id_q     <= '0;
      vec_q        <= PC_WIDTH'(VECTOR_BASE);
    end else begin
      case (state_q)
        INTC_STATE_IDLE: begin
          if (sreg_i && pipeline_ready && sel_valid) begin
            state_q  <= INTC_STATE_REQUEST;
            irq_q    <= 1'b1;
            irq_id_q <= sel_idx;
            vec_q    <= vec_sel;
          end
        end
        INTC_STATE_REQUEST: begin
          if (irq_ack) begin
            state_q      <= INTC_STATE_IN_SERVICE;
            irq_q        <= 1'b0;
            in_service_q <= 1'b1;
          end else if (!sreg_i) begin
            state_q <= INTC_STATE_IDLE;
            irq_q   <= 1'b0;
          end
        end
        INTC_STATE_IN_SERVICE: begin
          if (reti_done) begin
            state_q      <= INTC_STATE_IDLE;
            in_service_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= INTC_STATE_IDLE;
          irq_q        <= 1'b0;
          in_service_q <= 1'b0;
        end
      endcase
    end
  end

  assign irq        = irq_q;
  assign in_service = in_service_q;
  assign irq_id     = irq_id_q;
  assign isr_vector = vec_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller; a second instance uses a wrapping
// vector base to exercise the modulo arithmetic.
module tb_interrupt_controller;

  logic       clk = 1'b0;
  logic       reset, sreg_i, pipeline_ready, irq_ack, reti_done;
  logic [3:0] irq_lines;
`ifdef INTC_MASK_EN
  logic       mask_we;
  logic [3:0] mask_wdata;
`endif

  logic       irq, in_service, irq2, in_service2;
  logic [9:0] isr_vector, isr_vector2;
  logic [2:0] irq_id, irq_id2;
  logic [3:0] pending, pending2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  interrupt_controller #(.IRQ_COUNT(4), .PC_WIDTH(10), .VECTOR_BASE(1), .VECTOR_STRIDE(1)) dut (
    .clk(clk), .reset(reset), .irq_lines(irq_lines), .sreg_i(sreg_i),
    .pipeline_ready(pipeline_ready), .irq_ack(irq_ack), .reti_done(reti_done),
`ifdef INTC_MASK_EN
    .mask_we(mask_we), .mask_wdata(mask_wdata),
`endif
    .irq(irq), .isr_vector(isr_vector), .irq_id(irq_id),
    .pending(pending), .in_service(in_service)
  );

  interrupt_controller #(.IRQ_COUNT(4), .PC_WIDTH(10), .VECTOR_BASE(1020), .VECTOR_STRIDE(2)) dut2 (
    .clk(clk), .reset(reset), .irq_lines(irq_lines), .sreg_i(sreg_i),
    .pipeline_ready(pipeline_ready), .irq_ack(irq_ack), .reti_done(reti_done),
`ifdef INTC_MASK_EN
    .mask_we(mask_we), .mask_wdata(mask_wdata),
`endif
    .irq(irq2), .isr_vector(isr_vector2), .irq_id(irq_id2),
    .pending(pending2), .in_service(in_service2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1; sreg_i = 0; pipeline_ready = 0; irq_ack = 0; reti_done = 0; irq_lines = '0;
`ifdef INTC_MASK_EN
    mask_we = 0; mask_wdata = '0;
`endif
    step(); step();
    chk("rst_irq", irq, 0);
    chk("rst_insvc", in_service, 0);
    chk("rst_pend", pending, 0);
    chk("rst_id", irq_id, 0);
    chk("rst_vec", isr_vector, 1);
    chk("rst_vec2", isr_vector2, 1020);
    reset = 0; sreg_i = 1; pipeline_ready = 1;
    step();

    // Single request on line 2
    irq_lines = 4'b0100; step();
    chk("t1_pend", pending, 4'b0100);
    chk("t1_irq_early", irq, 0);
    step();
    chk("t1_irq", irq, 1);
    chk("t1_id", irq_id, 2);
    chk("t1_vec", isr_vector, 3);
    step();
    chk("t1_irq_hold", irq, 1);
    irq_ack = 1; step(); irq_ack = 0;
    chk("t1_pend_clr", pending, 0);
    chk("t1_insvc", in_service, 1);
    chk("t1_irq_drop", irq, 0);
    step(); step();
    chk("t1_level_once", pending, 0);
    reti_done = 1; step(); reti_done = 0;
    chk("t1_reti", in_service, 0);
    irq_lines = '0; step();
    // Spurious pulses in IDLE
    reti_done = 1; irq_ack = 1; step(); reti_done = 0; irq_ack = 0;
    chk("spur_insvc", in_service, 0);
    chk("spur_irq", irq, 0);

    // Simultaneous edges: line 1 then line 3
    irq_lines = 4'b1010; step();
    chk("t2_pend", pending, 4'b1010);
    step();
    chk("t2_id1", irq_id, 1);
    chk("t2_vec1", isr_vector, 2);
    chk("t2_vec1_b", isr_vector2, 1022);
    irq_ack = 1; step(); irq_ack = 0;
    chk("t2_pend_after", pending, 4'b1000);
    reti_done = 1; step(); reti_done = 0;
    step();
    chk("t2_irq3", irq, 1);
    chk("t2_id3", irq_id, 3);
    chk("t2_vec3", isr_vector, 4);
    chk("t5_wrap", isr_vector2, 2);
    chk("t5_id", irq_id2, 3);
    irq_ack = 1; step(); irq_ack = 0;
    reti_done = 1; step(); reti_done = 0;
    chk("t2_done_pend", pending, 0);
    irq_lines = '0; step();

    // Global enable gating and withdraw
    sreg_i = 0; irq_lines = 4'b0001; step();
    chk("t3_pend", pending, 4'b0001);
    step(); step();
    chk("t3_gated", irq, 0);
    sreg_i = 1; step();
    chk("t3_req", irq, 1);
    chk("t3_id", irq_id, 0);
    sreg_i = 0; step();
    chk("t3_withdraw", irq, 0);
    chk("t3_pend_kept", pending, 4'b0001);
    sreg_i = 1; step();
    chk("t3_rereq", irq, 1);
    sreg_i = 0; irq_ack = 1; step(); irq_ack = 0; sreg_i = 1;
    chk("t3_ack_wins", in_service, 1);
    chk("t3_pend_clr", pending, 0);
    step();
    chk("t3_no_nest", irq, 0);
    reti_done = 1; step(); reti_done = 0;
    irq_lines = '0; step();

    // New edge coincides with ack of same line
    irq_lines = 4'b0100; step(); step();
    chk("t4_req", irq_id, 2);
    irq_lines = '0; step();
    irq_lines = 4'b0100; irq_ack = 1; step(); irq_ack = 0;
    chk("t4_set_wins", pending, 4'b0100);
    chk("t4_insvc", in_service, 1);
    reti_done = 1; step(); reti_done = 0;
    step();
    chk("t4_second", irq, 1);
    chk("t4_second_id", irq_id, 2);
    irq_ack = 1; step(); irq_ack = 0;
    reti_done = 1; step(); reti_done = 0;
    irq_lines = '0; step();

    // Reset during IN_SERVICE with pending 1010
    irq_lines = 4'b1010; step(); step();
    irq_ack = 1; step(); irq_ack = 0;
    irq_lines = '0; step();
    irq_lines = 4'b0010; step();
    chk("t6_pre_pend", pending, 4'b1010);
    chk("t6_pre_insvc", in_service, 1);
    reset = 1; irq_lines = '0; step();
    chk("t6_irq", irq, 0);
    chk("t6_insvc", in_service, 0);
    chk("t6_pend", pending, 0);
    chk("t6_id", irq_id, 0);
    chk("t6_vec", isr_vector, 1);
    chk("t6_b_all", {irq2, in_service2, pending2}, 0);
    reset = 0; step();

`ifdef INTC_MASK_EN
    mask_we = 1; mask_wdata = 4'b1110; step(); mask_we = 0;
    irq_lines = 4'b0001; step(); step(); step();
    chk("m_pend", pending, 4'b0001);
    chk("m_masked", irq, 0);
    mask_we = 1; mask_wdata = 4'b0000; step(); mask_we = 0;
    chk("m_still", irq, 0);
    mask_we = 1; mask_wdata = 4'b1111; step(); mask_we = 0;
    step();
    chk("m_unmask", irq, 1);
    chk("m_id", irq_id, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
